// File: rtl/alu_trace_uart.sv
// Capture side of the sm83_alu test harness: queues tagged ALU samples in a FIFO
// and streams each one to the host as three 8N1 bytes.
//
// state   | meaning
// S_IDLE  | line high, waiting for a queued record
// S_START | start bit (tx=0) for the current byte
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (tx=1), then next byte or back to idle
module alu_trace_uart #(
   parameter int CLK_DIV    = 104,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cap_valid,
   input  logic [6:0]            cap_tag,
   input  logic [7:0]            cap_result,
   input  logic                  cap_carry,
   input  logic                  cap_halfcarry,
   input  logic                  cap_zero,
   output logic                  tx,
   output logic                  busy,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  overflow,
   output logic [7:0]            drop_count
);

   localparam int                DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [15:0]       DIV_M1     = 16'(CLK_DIV - 1);
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   function automatic logic [7:0] rec_byte(input logic [17:0] rec, input logic [1:0] idx);
      case (idx)
         2'd0:    return {1'b1, rec[17:11]};
         2'd1:    return rec[10:3];
         default: return {5'b00000, rec[2:0]};
      endcase
   endfunction

   logic [17:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            drop_q, drop_d;
   state_t                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [2:0]            bit_q, bit_d;
   logic [1:0]            byte_q, byte_d;
   logic [7:0]            shift_q, shift_d;
   logic [17:0]           rec_q, rec_d;
   logic                  tx_q, tx_d;
   logic                  full, push, drop, pop;

   // Fullness is judged on the pre-edge level, so a same-cycle pop never frees a slot.
   assign full = (level_q == FULL_LEVEL);
   assign push = cap_valid && !full;
   assign drop = cap_valid && full;
   assign pop  = (state_q == S_IDLE) && (level_q != '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
         2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
         default: level_d = level_q;
      endcase
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      rec_d   = rec_q;
      tx_d    = tx_q;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               state_d = S_START;
               cnt_d   = DIV_M1;
               byte_d  = 2'd0;
               rec_d   = mem_q[rd_ptr_q];
               shift_d = rec_byte(mem_q[rd_ptr_q], 2'd0);
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               state_d = S_DATA;
               cnt_d   = DIV_M1;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = DIV_M1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (byte_q != 2'd2) begin
                  state_d = S_START;
                  cnt_d   = DIV_M1;
                  byte_d  = byte_q + 2'd1;
                  shift_d = rec_byte(rec_q, byte_q + 2'd1);
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cap_tag, cap_result, cap_carry, cap_halfcarry, cap_zero};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= 8'd0;
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         bit_q      <= 3'd0;
         byte_q     <= 2'd0;
         shift_q    <= 8'd0;
         rec_q      <= 18'd0;
         tx_q       <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         rec_q      <= rec_d;
         tx_q       <= tx_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != S_IDLE);
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_alu_trace_uart.sv
// Directed bench for alu_trace_uart: three instances (deep FIFO, shallow FIFO,
// stalled line) share the capture bus; UART bytes are decoded from tx.
module tb_alu_trace_uart;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a = 1'b1, reset_b = 1'b1, reset_c = 1'b1;
   logic       val_a = 1'b0, val_b = 1'b0, val_c = 1'b0;
   logic [6:0] tag = '0;
   logic [7:0] res = '0;
   logic       cf = 1'b0, hf = 1'b0, zf = 1'b0;

   logic       tx_a, busy_a, ovf_a, tx_b, busy_b, ovf_b, tx_c, busy_c, ovf_c;
   logic [4:0] lvl_a;
   logic [2:0] lvl_b, lvl_c;
   logic [7:0] drop_a, drop_b, drop_c;

   int checks = 0;
   int failures = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   alu_trace_uart #(.CLK_DIV(4), .DEPTH_LOG2(4)) u_a (
      .clk(clk), .reset(reset_a), .cap_valid(val_a), .cap_tag(tag), .cap_result(res),
      .cap_carry(cf), .cap_halfcarry(hf), .cap_zero(zf), .tx(tx_a), .busy(busy_a),
      .fifo_level(lvl_a), .overflow(ovf_a), .drop_count(drop_a));

   alu_trace_uart #(.CLK_DIV(4), .DEPTH_LOG2(2)) u_b (
      .clk(clk), .reset(reset_b), .cap_valid(val_b), .cap_tag(tag), .cap_result(res),
      .cap_carry(cf), .cap_halfcarry(hf), .cap_zero(zf), .tx(tx_b), .busy(busy_b),
      .fifo_level(lvl_b), .overflow(ovf_b), .drop_count(drop_b));

   alu_trace_uart #(.CLK_DIV(65535), .DEPTH_LOG2(2)) u_c (
      .clk(clk), .reset(reset_c), .cap_valid(val_c), .cap_tag(tag), .cap_result(res),
      .cap_carry(cf), .cap_halfcarry(hf), .cap_zero(zf), .tx(tx_c), .busy(busy_c),
      .fifo_level(lvl_c), .overflow(ovf_c), .drop_count(drop_c));

   // 8N1 receivers for CLK_DIV=4: first low sample is half a cycle into the
   // start bit, so each bit is then sampled 2.5 cycles into its period.
   always begin : rx_a
      logic [7:0] b;
      do @(negedge clk); while (tx_a !== 1'b0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         b[i] = tx_a;
      end
      repeat (4) @(negedge clk);
      q_a.push_back(b);
   end

   always begin : rx_b
      logic [7:0] b;
      do @(negedge clk); while (tx_b !== 1'b0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         b[i] = tx_b;
      end
      repeat (4) @(negedge clk);
      q_b.push_back(b);
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cap_a(input logic [6:0] t, input logic [7:0] r, input logic c, h, z);
      tag = t; res = r; cf = c; hf = h; zf = z;
      val_a = 1'b1;
      tick(1);
      val_a = 1'b0;
   endtask

   task automatic wait_rx(input int which, input int n, input int bound);
      int t = 0;
      while (((which == 0) ? q_a.size() : q_b.size()) < n && t < bound) begin
         tick(1);
         t++;
      end
      chk("rx_timeout", 32'(t < bound), 32'd1);
      tick(5);
   endtask

   function automatic logic [23:0] take_a();
      logic [23:0] v = 'x;
      if (q_a.size() >= 3) begin
         v[23:16] = q_a.pop_front();
         v[15:8]  = q_a.pop_front();
         v[7:0]   = q_a.pop_front();
      end
      return v;
   endfunction

   function automatic logic [23:0] take_b();
      logic [23:0] v = 'x;
      if (q_b.size() >= 3) begin
         v[23:16] = q_b.pop_front();
         v[15:8]  = q_b.pop_front();
         v[7:0]   = q_b.pop_front();
      end
      return v;
   endfunction

   initial begin
      int act;
      logic [2:0] fl;
      tick(3);
      chk("rst_tx", 32'(tx_a), 32'd1);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_level", 32'(lvl_a), 32'd0);
      chk("rst_overflow", 32'(ovf_a), 32'd0);
      chk("rst_drop", 32'(drop_a), 32'd0);
      reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
      tick(2);

      // single record, timing of start bit and busy
      cap_a(7'h05, 8'h3C, 1'b1, 1'b0, 1'b0);
      chk("t1_level_push", 32'(lvl_a), 32'd1);
      chk("t1_tx_idle", 32'(tx_a), 32'd1);
      tick(1);
      chk("t1_level_pop", 32'(lvl_a), 32'd0);
      chk("t1_busy_hi", 32'(busy_a), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("t1_start_bit", 32'(tx_a), 32'd0);
         tick(1);
      end
      chk("t1_data0", 32'(tx_a), 32'd1);
      tick(115);
      chk("t1_busy_last", 32'(busy_a), 32'd1);
      tick(1);
      chk("t1_busy_lo", 32'(busy_a), 32'd0);
      chk("t1_rx_count", 32'(q_a.size()), 32'd3);
      chk("t1_bytes", 32'(take_a()), 32'h00853C04);

      // zero result, all-ones tag
      cap_a(7'h7F, 8'h00, 1'b0, 1'b0, 1'b1);
      wait_rx(0, 3, 300);
      chk("zero_bytes", 32'(take_a()), 32'h00FF0001);

      // reset in the middle of byte1 with a second record queued
      cap_a(7'h11, 8'h55, 1'b0, 1'b1, 1'b0);
      cap_a(7'h12, 8'h66, 1'b0, 1'b0, 1'b0);
      tick(58);
      chk("mid_busy", 32'(busy_a), 32'd1);
      chk("mid_level", 32'(lvl_a), 32'd1);
      reset_a = 1'b1;
      tick(1);
      reset_a = 1'b0;
      chk("mid_rst_tx", 32'(tx_a), 32'd1);
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_level", 32'(lvl_a), 32'd0);
      act = 0;
      for (int k = 0; k < 60; k++) begin
         if (tx_a !== 1'b1 || busy_a !== 1'b0) act++;
         tick(1);
      end
      chk("mid_quiet", 32'(act), 32'd0);
      q_a.delete();
      cap_a(7'h2A, 8'hA5, 1'b1, 1'b1, 1'b1);
      wait_rx(0, 3, 300);
      chk("mid_after_bytes", 32'(take_a()), 32'h00AAA507);
      chk("mid_after_empty", 32'(q_a.size()), 32'd0);

      // 4-deep FIFO, 8 back-to-back captures
      val_b = 1'b1;
      for (int k = 0; k < 8; k++) begin
         fl = 3'(k);
         tag = 7'(k); res = 8'(k * 17); {cf, hf, zf} = fl;
         tick(1);
         chk("ovf_level", 32'(lvl_b), (k == 0) ? 32'd1 : (k > 4) ? 32'd4 : 32'(k));
      end
      val_b = 1'b0;
      chk("ovf_flag", 32'(ovf_b), 32'd1);
      chk("ovf_drops", 32'(drop_b), 32'd3);
      wait_rx(1, 15, 800);
      for (int k = 0; k < 5; k++) begin
         fl = 3'(k);
         chk("ovf_record", 32'(take_b()), 32'({1'b1, 7'(k), 8'(k * 17), 5'b00000, fl}));
      end
      chk("ovf_no_extra", 32'(q_b.size()), 32'd0);

      // stalled line: drop counter saturation
      val_c = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tag = 7'(i);
         tick(1);
         if (i == 5)   chk("sat_first_drop", 32'(drop_c), 32'd1);
         if (i == 258) chk("sat_254", 32'(drop_c), 32'd254);
         if (i == 259) chk("sat_255", 32'(drop_c), 32'd255);
      end
      val_c = 1'b0;
      chk("sat_final", 32'(drop_c), 32'd255);
      chk("sat_level", 32'(lvl_c), 32'd4);
      tick(20);
      chk("sat_ovf_sticky", 32'(ovf_c), 32'd1);
      reset_c = 1'b1;
      tick(1);
      reset_c = 1'b0;
      chk("sat_rst_ovf", 32'(ovf_c), 32'd0);
      chk("sat_rst_drop", 32'(drop_c), 32'd0);
      chk("sat_rst_tx", 32'(tx_c), 32'd1);

      // 40 spaced records through the 16-deep FIFO (pointers wrap)
      q_a.delete();
      for (int r = 0; r < 40; r++) begin
         fl = 3'(r);
         cap_a(7'(r), 8'(r * 7 + 3), fl[0], fl[1], fl[2]);
         tick(129);
      end
      wait_rx(0, 120, 400);
      for (int r = 0; r < 40; r++) begin
         fl = 3'(r);
         chk("long_record", 32'(take_a()),
             32'({1'b1, 7'(r), 8'(r * 7 + 3), 5'b00000, fl[0], fl[1], fl[2]}));
      end
      chk("long_overflow", 32'(ovf_a), 32'd0);
      chk("long_level", 32'(lvl_a), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
